// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and block/latency constants for mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int MEM_LATENCY = 4;

    function automatic logic is_fill(input state_t s);
        return s == FILL_I || s == FILL_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// fill_counter: 3-bit up-counter with clear; o_full marks that MAX+1 increments
// have been seen, so the count never wraps back to zero.
module fill_counter #(
    parameter logic [2:0] MAX = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [2:0] o_cnt,
    output logic       o_full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_clr) begin
            o_cnt  <= '0;
            o_full <= 1'b0;
        end else if (i_inc && !o_full) begin
            if (o_cnt == MAX) o_full <= 1'b1;
            else o_cnt <= o_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory between I/D cache block fills and
// D-side write-through stores.
module mem_arbiter #(
    parameter int BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [15:0]       d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       fill_data,
    output logic [2:0]        fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_done,
    output logic              d_done,
    output logic              d_wr_ack,
    output logic              busy
);
    import mem_arb_pkg::*;

    localparam logic [2:0] LAST = 3'(BLOCK_WORDS - 1);

    state_t            r_state;
    state_t            w_grant;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic              r_last_d;
    logic [2:0]        w_iss_cnt;
    logic [2:0]        w_ret_cnt;
    logic              w_iss_full;
    logic              w_ret_full;
    logic              w_fill;
    logic              w_issue;
    logic              w_ret;
    logic              w_last;

    assign w_fill  = is_fill(r_state);
    assign w_issue = w_fill && !w_iss_full;
    assign w_ret   = w_fill && mem_valid && !w_ret_full;
    assign w_last  = w_ret && w_ret_cnt == LAST;

    fill_counter #(.MAX(LAST)) u_issue (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!w_fill),
        .i_inc  (w_issue),
        .o_cnt  (w_iss_cnt),
        .o_full (w_iss_full)
    );

    fill_counter #(.MAX(LAST)) u_return (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!w_fill),
        .i_inc  (w_ret),
        .o_cnt  (w_ret_cnt),
        .o_full (w_ret_full)
    );

    // Stores first; competing fills go to whichever side was not served last.
    assign w_grant = d_wr_req                          ? WRITE  :
                     (d_req && (!i_req || !r_last_d)) ? FILL_D :
                     i_req                             ? FILL_I : IDLE;
    assign w_next  = (r_state == IDLE)                ? w_grant :
                     (r_state == WRITE || w_last)     ? IDLE    : r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_last_d <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && is_fill(w_next)) begin
                r_base   <= (w_next == FILL_D ? d_addr : i_addr) & ~ADDR_W'(4'hF);
                r_last_d <= w_next == FILL_D;
            end
        end
    end

    assign busy      = r_state != IDLE;
    assign mem_wr    = r_state == WRITE;
    assign mem_en    = w_issue || mem_wr;
    assign mem_addr  = mem_wr ? d_wr_addr : w_issue ? r_base + ADDR_W'({w_iss_cnt, 1'b0}) : '0;
    assign mem_wdata = mem_wr ? d_wr_data : '0;
    assign d_wr_ack  = mem_wr;
    assign fill_data = w_ret ? mem_rdata : '0;
    assign fill_word = w_ret ? w_ret_cnt : '0;
    assign i_fill_we = w_ret && r_state == FILL_I;
    assign d_fill_we = w_ret && r_state == FILL_D;
    assign i_done    = w_last && r_state == FILL_I;
    assign d_done    = w_last && r_state == FILL_D;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a fixed-latency memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy;
    logic        stray = 1'b0;
    logic [58:0] all_out;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wr_req  (d_wr_req),
        .d_wr_addr (d_wr_addr),
        .d_wr_data (d_wr_data),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .fill_data (fill_data),
        .fill_word (fill_word),
        .i_fill_we (i_fill_we),
        .d_fill_we (d_fill_we),
        .i_done    (i_done),
        .d_done    (d_done),
        .d_wr_ack  (d_wr_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory: a read issued in cycle t returns addr^0x5A5A in cycle t+MEM_LATENCY.
    logic [MEM_LATENCY-1:0] r_v = '0;
    logic [15:0]            r_a [MEM_LATENCY];

    always @(posedge clk) begin
        r_v    <= {r_v[MEM_LATENCY-2:0], mem_en && !mem_wr};
        r_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LATENCY; i++) r_a[i] <= r_a[i-1];
    end

    assign mem_valid = r_v[MEM_LATENCY-1] | stray;
    assign mem_rdata = r_a[MEM_LATENCY-1] ^ 16'h5A5A;
    assign all_out   = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                        i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Enters a fill from the current IDLE cycle and checks all 12 fill cycles.
    task automatic run_fill(input bit is_d, input logic [15:0] addr, input int drop_at, input int wr_at);
        logic [15:0] base;
        logic [42:0] exp_v, obs;
        logic        fwe;
        int          k;
        base = addr & 16'hFFF0;
        for (int c = 0; c < 12; c++) begin
            step;
            if (c == drop_at) begin
                if (is_d) d_req = 1'b0;
                else i_req = 1'b0;
            end
            if (c == wr_at) d_wr_req = 1'b1;
            k = c - 4;
            exp_v = {(c < 8), 1'b0, (c < 8) ? base + 16'(2 * c) : 16'h0,
                     (!is_d && c >= 4), (is_d && c >= 4),
                     (c >= 4) ? 3'(k) : 3'd0,
                     (c >= 4) ? (base + 16'(2 * k)) ^ 16'h5A5A : 16'h0,
                     (!is_d && c == 11), (is_d && c == 11), 1'b0, 1'b1};
            fwe = i_fill_we | d_fill_we;
            obs = {mem_en, mem_wr, mem_en ? mem_addr : 16'h0, i_fill_we, d_fill_we,
                   fwe ? fill_word : 3'd0, fwe ? fill_data : 16'h0,
                   i_done, d_done, d_wr_ack, busy};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL fill_%s cycle %0d: got %h expected %h", is_d ? "d" : "i", c, obs, exp_v);
            end
        end
        if (is_d) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        i_req = 1'b1;
        #1;
        n_chk++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_chk++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0", all_out);
        end
        i_req = 1'b0;
        rst   = 1'b0;
        step;
    endtask

    task automatic test_arbitration;
        d_addr = 16'h1234;
        i_addr = 16'h5678;
        d_req  = 1'b1;
        i_req  = 1'b1;
        run_fill(1'b1, 16'h1234, -1, -1);
        d_req = 1'b1;
        step;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_idle_gap1: busy got %b expected 0", busy);
        end
        run_fill(1'b0, 16'h5678, -1, -1);
        i_req = 1'b1;
        step;
        run_fill(1'b1, 16'h1234, -1, -1);
        step;
        run_fill(1'b0, 16'h5678, -1, -1);
        step;
    endtask

    task automatic test_fill_i;
        i_addr = 16'h0136;
        i_req  = 1'b1;
        run_fill(1'b0, 16'h0136, -1, -1);
        step;
        n_chk++;
        if ({busy, mem_en, i_fill_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL fill_i_idle: got %b expected 000", {busy, mem_en, i_fill_we});
        end
    endtask

    task automatic test_write;
        d_wr_addr = 16'h0010;
        d_wr_data = 16'h1234;
        d_wr_req  = 1'b1;
        step;
        n_chk++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, busy, i_fill_we, d_fill_we} !==
            {1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL write_cycle: got %h expected %h",
                     {mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, busy, i_fill_we, d_fill_we},
                     {1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        d_wr_req = 1'b0;
        step;
        n_chk++;
        if ({d_wr_ack, mem_en, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL write_one_cycle: got %b expected 000", {d_wr_ack, mem_en, busy});
        end
    endtask

    task automatic test_write_deferred;
        int waited;
        d_addr    = 16'h0350;
        d_wr_addr = 16'h0200;
        d_wr_data = 16'hBEEF;
        d_req     = 1'b1;
        run_fill(1'b1, 16'h0350, -1, 3);
        waited = 0;
        for (int j = 1; j <= 3 && waited == 0; j++) begin
            step;
            if (d_wr_ack) waited = j;
        end
        n_chk++;
        if (waited == 0 || waited > 2) begin
            n_fail++;
            $display("FAIL deferred_write_timing: ack after %0d cycles expected 1..2", waited);
        end
        n_chk++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we} !==
            {1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL deferred_write_bus: got %h expected %h",
                     {mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we},
                     {1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0, 1'b0});
        end
        d_wr_req = 1'b0;
        step;
        n_chk++;
        if ({d_wr_ack, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL deferred_write_end: got %b expected 00", {d_wr_ack, busy});
        end
    endtask

    task automatic test_drop_and_stray;
        i_addr = 16'h07F2;
        i_req  = 1'b1;
        run_fill(1'b0, 16'h07F2, 1, -1);
        step;
        stray = 1'b1;
        #1;
        n_chk++;
        if ({i_fill_we, d_fill_we, fill_word, fill_data, i_done, d_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL stray_valid_idle: got %h expected 0",
                     {i_fill_we, d_fill_we, fill_word, fill_data, i_done, d_done, busy});
        end
        step;
        stray = 1'b0;
    endtask

    task automatic test_reset_mid_fill;
        logic bad;
        d_addr = 16'h0480;
        d_req  = 1'b1;
        for (int c = 0; c <= 6; c++) step;
        n_chk++;
        if ({d_fill_we, fill_word} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL rst_mid_third_word: got %b expected 1010", {d_fill_we, fill_word});
        end
        rst   = 1'b1;
        d_req = 1'b0;
        #1;
        n_chk++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 0", all_out);
        end
        step;
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step;
            bad = bad | d_done | d_fill_we | i_fill_we | busy | mem_en;
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: activity flag got %b expected 0", bad);
        end
        d_req = 1'b1;
        run_fill(1'b1, 16'h0480, -1, -1);
        step;
    endtask

    initial begin
        test_reset;
        test_arbitration;
        test_fill_i;
        test_write;
        test_write_deferred;
        test_drop_and_stray;
        test_reset_mid_fill;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
